uart_receiver_parametrised: RTL and testbench
=============================================

Name: uart_receiver_parametrised

Overview:
Parametrised UART receive block, the successor to the first-generation UART receiver. It runs on the system clock and generates its own oversampling tick internally. It supports 5–9 data bits, optional even/odd parity, and 1 or 2 stop bits. Each received word is held until it is acknowledged, and frames are flagged for parity, framing and overrun errors. It sits between the rx pin and the handwriting-data loader.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, ticks per bit period (even, >=8)
CLKS_PER_TICK, 56, clk cycles per oversample tick (100 MHz / (112000*16) ≈ 56)
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
data_ack  input  1  consumer accepts data; sampled on clk
data  output  DATA_BITS  last received word
data_valid  output  1  level; high while data holds an unacknowledged word
parity_error  output  1  parity mismatch for the word in data
framing_error  output  1  a stop bit was sampled 0 for the word in data
overrun_error  output  1  sticky; a frame completed while data_valid was high
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; tick and sample counters 0; synchroniser flops 1.
- rx synchroniser:
  - rx passes through a 2-flop synchroniser; all logic uses rx_s.
  - rx-to-rx_s latency is 2 clk.
- Tick generator:
  - Counter runs 0..CLKS_PER_TICK-1; tick is a 1-clk pulse when count==CLKS_PER_TICK-1.
  - The counter is cleared on IDLE->START, so bit timing is aligned to the start edge.
- Sample counter:
  - Width $clog2(OVERSAMPLE), incremented on each tick.
  - Cleared on every state change and after each bit decision.
- Bit decision:
  - Taken on the tick where the sample count reaches OVERSAMPLE-1.
  - The decided value is rx_s at that tick, unless MAJORITY_VOTE_EN is defined.
- State machine:
  - IDLE: rx_s==0 -> START.
  - START: at sample count OVERSAMPLE/2-1, if rx_s==0 -> DATA (count cleared, so later decisions fall at bit centres); else false start -> IDLE with no output change.
  - DATA: shift the decided bit into the MSB of a DATA_BITS shift register (LSB first). After DATA_BITS decisions -> PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: decide 1 bit. The error is XOR(data bits, parity bit) != (PARITY_MODE==2). -> STOP.
  - STOP: decide STOP_BITS bits; any 0 sets the pending framing flag. After the last stop decision -> IDLE and the frame completes in the same clk.
- Frame completion (1 clk, registered):
  - data <= shift register; parity_error and framing_error <= pending flags; data_valid <= 1.
  - If data_valid was already 1 and data_ack was not asserted that cycle, overrun_error <= 1.
  - The new word overwrites the old one.
- Handshake:
  - data_ack while data_valid=1 clears data_valid next clk.
  - parity_error and framing_error keep their value until the next completion.
  - data_ack while data_valid=0 is ignored.
  - Completion and data_ack in the same clk: data_valid stays 1 with the new word; no overrun.
- overrun_error clears only on reset.
- Framing error does not stall the block:
  - Return to IDLE is immediate.
  - If rx stays low (break), IDLE re-enters START and the false-start path repeats until rx goes high.
- Timing: from the rx falling edge to data_valid is (1.5 + DATA_BITS + parity + STOP_BITS − 1) × OVERSAMPLE × CLKS_PER_TICK clk, with a tolerance of ±(CLKS_PER_TICK + 3) clk.
- Reset mid-frame aborts the frame: no completion pulse, all outputs 0.

Optional Feature:
MAJORITY_VOTE_EN
- Defined:
  - The decided bit (including the start-bit check) is the majority of rx_s sampled on the ticks at counts OVERSAMPLE-3, OVERSAMPLE-2 and OVERSAMPLE-1.
  - A single-tick glitch inside that window does not change the decision.
- Undefined:
  - Single sample at count OVERSAMPLE-1; no extra sample flops.

Test Plan:
Bench settings: CLKS_PER_TICK=4, OVERSAMPLE=16 (64 clk per bit).
1. Frame 0xA5, 8N1 -> data=0xA5, data_valid=1 at ~600 clk after the start edge, no error flags. Then data_ack=1 for 1 clk -> data_valid=0 next clk.
2. PARITY_MODE=1 (even): send 0x03 with parity bit 0 -> no error. Send 0x03 with parity bit 1 -> parity_error=1, data=0x03.
3. Stop bit driven 0 -> framing_error=1, data_valid=1. Next clean frame 0x5A -> framing_error=0.
4. Two frames 0x11 and 0x22 with no data_ack -> data=0x22, overrun_error=1 and stays 1 until reset. Repeat with data_ack asserted on the completion clk -> overrun_error stays 0.
5. rx low pulse of 20 clk, then high -> false start: busy returns to 0, data_valid stays 0. Reset asserted halfway through a 0xFF frame -> all outputs 0, next frame 0x3C received correctly.
6. MAJORITY_VOTE_EN: 1-clk-wide 1-glitch at count OVERSAMPLE-2 of data bit 0 of frame 0x00 -> data=0x00. Without the macro, a glitch at count OVERSAMPLE-1 -> data=0x01.

Source files
------------

// File: rtl/uart_receiver_parametrised.sv
// Oversampling UART receiver with configurable data/parity/stop format and a
// held-until-acknowledged output word. Define MAJORITY_VOTE_EN for 3-sample majority bit decisions.
module uart_receiver_parametrised #(
    parameter int DATA_BITS     = 8,
    parameter int OVERSAMPLE    = 16,
    parameter int CLKS_PER_TICK = 56,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    input  logic                 data_ack_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    output logic                 parity_error_o,
    output logic                 framing_error_o,
    output logic                 overrun_error_o,
    output logic                 busy_o
);

    localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]        samp_q, samp_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_pend_q, perr_pend_d;
    logic                 ferr_pend_q, ferr_pend_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, perr_q, ferr_q, ovr_q;
    logic                 tick, decide, bit_val, complete;
    logic [SW-1:0]        decide_cnt;

    assign tick       = (tick_cnt_q == TICK_LAST);
    // The start bit is checked at its centre; later decisions land one bit period apart.
    assign decide_cnt = (state_q == START) ? SAMP_MID : SAMP_LAST;
    assign decide     = tick && (samp_q == decide_cnt);

`ifdef MAJORITY_VOTE_EN
    logic vote0_q, vote1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vote0_q <= 1'b1;
            vote1_q <= 1'b1;
        end else begin
            if (tick && (samp_q == decide_cnt - SW'(2))) vote0_q <= rx_s_q;
            if (tick && (samp_q == decide_cnt - SW'(1))) vote1_q <= rx_s_q;
        end
    end

    assign bit_val = (vote0_q & vote1_q) | (vote0_q & rx_s_q) | (vote1_q & rx_s_q);
`else
    assign bit_val = rx_s_q;
`endif

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
        samp_d      = tick ? samp_q + SW'(1) : samp_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        complete    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d     = START;
                    tick_cnt_d  = '0;
                    bit_cnt_d   = '0;
                    perr_pend_d = 1'b0;
                    ferr_pend_d = 1'b0;
                end
            end
            START: begin
                if (decide) state_d = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (decide) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    perr_pend_d = (((^shift_q) ^ bit_val) != (PARITY_MODE == 2));
                    state_d     = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (!bit_val) ferr_pend_d = 1'b1;
                    if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                        state_d  = IDLE;
                        complete = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (decide || (state_d != state_q)) samp_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            tick_cnt_q  <= '0;
            samp_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_i;
            rx_s_q      <= rx_meta_q;
            tick_cnt_q  <= tick_cnt_d;
            samp_q      <= samp_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
        end
    end

    // A completing frame always wins over a same-cycle acknowledge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (complete) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
            perr_q  <= perr_pend_q;
            ferr_q  <= ferr_pend_d;
            if (valid_q && !data_ack_i) ovr_q <= 1'b1;
        end else if (valid_q && data_ack_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o          = data_q;
    assign data_valid_o    = valid_q;
    assign parity_error_o  = perr_q;
    assign framing_error_o = ferr_q;
    assign overrun_error_o = ovr_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver_parametrised.sv
// Scoreboard bench for uart_receiver_parametrised: an 8N1 instance and an 8E2 instance,
// 64 clk per bit; expected words are queued at stimulus time and checked by a monitor.
module tb_uart_receiver_parametrised;
    localparam int BITCLK = 64;
    localparam int NOM_N  = 608;   // (1.5+8+0+1-1)*64
    localparam int NOM_P  = 736;   // (1.5+8+1+2-1)*64
    localparam int TOL    = 7;     // CLKS_PER_TICK + 3

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rx_n, rx_p, ack_n, ack_p;
    logic [7:0] d_n, d_p;
    logic       v_n, pe_n, fe_n, oe_n, b_n;
    logic       v_p, pe_p, fe_p, oe_p, b_p;

    uart_receiver_parametrised #(.DATA_BITS(8), .OVERSAMPLE(16), .CLKS_PER_TICK(4),
                                 .PARITY_MODE(0), .STOP_BITS(1)) dut_n (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_n), .data_ack_i(ack_n),
        .data_o(d_n), .data_valid_o(v_n), .parity_error_o(pe_n),
        .framing_error_o(fe_n), .overrun_error_o(oe_n), .busy_o(b_n));

    uart_receiver_parametrised #(.DATA_BITS(8), .OVERSAMPLE(16), .CLKS_PER_TICK(4),
                                 .PARITY_MODE(1), .STOP_BITS(2)) dut_p (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_p), .data_ack_i(ack_p),
        .data_o(d_p), .data_valid_o(v_p), .parity_error_o(pe_p),
        .framing_error_o(fe_p), .overrun_error_o(oe_p), .busy_o(b_p));

    typedef struct {
        logic [7:0] data;
        logic       pe, fe, oe;
        int         t0;
        int         nom;
    } exp_t;

    exp_t q_n[$];
    exp_t q_p[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic pe, input logic fe,
                        input logic oe);
        exp_t e;
        e.data = d; e.pe = pe; e.fe = fe; e.oe = oe; e.t0 = cyc;
        e.nom = (id == 0) ? NOM_N : NOM_P;
        if (id == 0) q_n.push_back(e);
        else         q_p.push_back(e);
    endtask

    task automatic mon(input int id, input logic [7:0] d, input logic pe, input logic fe,
                       input logic oe);
        exp_t e;
        int   lat;
        if ((id == 0 && q_n.size() == 0) || (id == 1 && q_p.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word dut%0d: got data 0x%0h with no word expected", id, d);
            return;
        end
        e = (id == 0) ? q_n.pop_front() : q_p.pop_front();
        check($sformatf("word_dut%0d {data,pe,fe,oe}", id), {20'h0, d, pe, fe, oe},
              {20'h0, e.data, e.pe, e.fe, e.oe});
        lat = cyc - e.t0;
        n_checks++;
        if (lat < e.nom - TOL || lat > e.nom + TOL) begin
            n_fail++;
            $display("FAIL latency_dut%0d: got %0d clk required %0d +/- %0d", id, lat, e.nom, TOL);
        end
    endtask

    logic       pv_n = 1'b0, pv_p = 1'b0;
    logic [7:0] pd_n = 8'h0, pd_p = 8'h0;
    logic [2:0] pf_n = 3'h0, pf_p = 3'h0;

    always @(negedge clk) begin
        if (v_n === 1'b1 && (!pv_n || d_n !== pd_n || {pe_n, fe_n, oe_n} !== pf_n))
            mon(0, d_n, pe_n, fe_n, oe_n);
        if (v_p === 1'b1 && (!pv_p || d_p !== pd_p || {pe_p, fe_p, oe_p} !== pf_p))
            mon(1, d_p, pe_p, fe_p, oe_p);
        pv_n <= v_n; pd_n <= d_n; pf_n <= {pe_n, fe_n, oe_n};
        pv_p <= v_p; pd_p <= d_p; pf_p <= {pe_p, fe_p, oe_p};
    end

    function automatic logic [15:0] mk(input logic [7:0] d, input logic hp, input logic p);
        logic [15:0] v;
        v      = 16'hFFFF;
        v[0]   = 1'b0;
        v[8:1] = d;
        if (hp) v[9] = p;
        return v;
    endfunction

    // Drives one clk per index from a negedge; indices inv_lo..inv_hi are inverted,
    // ack pulses at index ack_at, and index abort_at asserts reset and returns.
    task automatic send(input int id, input logic [15:0] bits, input int nbits, input int inv_lo,
                        input int inv_hi, input int ack_at, input int abort_at);
        logic b;
        for (int c = 0; c < nbits * BITCLK; c++) begin
            if (c == abort_at) begin
                check("busy_mid_frame", {31'h0, (id == 0) ? b_n : b_p}, 32'h1);
                rst_n = 1'b0;
                rx_n  = 1'b1;
                rx_p  = 1'b1;
                return;
            end
            b = bits[c / BITCLK] ^ (c >= inv_lo && c <= inv_hi);
            if (id == 0) begin rx_n = b; ack_n = (c == ack_at); end
            else         begin rx_p = b; ack_p = (c == ack_at); end
            @(negedge clk);
        end
        ack_n = 1'b0;
        ack_p = 1'b0;
    endtask

    task automatic do_ack(input int id);
        if (id == 0) ack_n = 1'b1; else ack_p = 1'b1;
        @(negedge clk);
        ack_n = 1'b0;
        ack_p = 1'b0;
        check($sformatf("valid_cleared_by_ack_dut%0d", id), {31'h0, (id == 0) ? v_n : v_p}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; rx_n = 1'b1; rx_p = 1'b1; ack_n = 1'b0; ack_p = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs_dut0", {18'h0, d_n, v_n, pe_n, fe_n, oe_n, b_n}, 32'h0);
        check("reset_outputs_dut1", {18'h0, d_p, v_p, pe_p, fe_p, oe_p, b_p}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic 8N1 frame and acknowledge
        push(0, 8'hA5, 0, 0, 0);
        send(0, mk(8'hA5, 0, 0), 14, -1, -1, -1, -1);
        check("valid_held_until_ack", {31'h0, v_n}, 32'h1);
        do_ack(0);

        // even parity, good then bad
        push(1, 8'h03, 0, 0, 0);
        send(1, mk(8'h03, 1, 0), 14, -1, -1, -1, -1);
        do_ack(1);
        push(1, 8'h03, 1, 0, 0);
        send(1, mk(8'h03, 1, 1), 14, -1, -1, -1, -1);
        do_ack(1);
        check("parity_error_kept_after_ack", {31'h0, pe_p}, 32'h1);

        // stop bit low for its first 40 clk -> framing error, then clean frame
        push(0, 8'hC3, 0, 1, 0);
        send(0, mk(8'hC3, 0, 0), 14, 9 * BITCLK, 9 * BITCLK + 39, -1, -1);
        check("idle_after_framing_error", {31'h0, b_n}, 32'h0);
        do_ack(0);
        push(0, 8'h5A, 0, 0, 0);
        send(0, mk(8'h5A, 0, 0), 14, -1, -1, -1, -1);
        do_ack(0);

        // overrun: two frames without acknowledge
        push(0, 8'h11, 0, 0, 0);
        send(0, mk(8'h11, 0, 0), 14, -1, -1, -1, -1);
        push(0, 8'h22, 0, 0, 1);
        send(0, mk(8'h22, 0, 0), 14, -1, -1, -1, -1);
        do_ack(0);
        check("overrun_sticky_after_ack", {31'h0, oe_n}, 32'h1);

        // false start: 20 clk low pulse
        send(0, 16'hFFFF, 4, 0, 19, -1, -1);
        check("false_start_busy", {31'h0, b_n}, 32'h0);
        check("false_start_valid", {31'h0, v_n}, 32'h0);

        // reset in the middle of a 0xFF frame
        send(0, mk(8'hFF, 0, 0), 14, -1, -1, -1, 300);
        repeat (2) @(negedge clk);
        check("mid_frame_reset_outputs", {18'h0, d_n, v_n, pe_n, fe_n, oe_n, b_n}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push(0, 8'h3C, 0, 0, 0);
        send(0, mk(8'h3C, 0, 0), 14, -1, -1, -1, -1);
        do_ack(0);

        // acknowledge on the completion clk of the second frame: no overrun
        push(0, 8'h11, 0, 0, 0);
        send(0, mk(8'h11, 0, 0), 14, -1, -1, -1, -1);
        push(0, 8'h22, 0, 0, 0);
        send(0, mk(8'h22, 0, 0), 14, -1, -1, NOM_N + 2, -1);
        check("valid_after_ack_on_completion", {31'h0, v_n}, 32'h1);
        check("no_overrun_ack_on_completion", {31'h0, oe_n}, 32'h0);
        do_ack(0);

        // single-clk glitches in data bit 0 of 0x00 (index 92 = count 14, 96 = count 15)
        push(0, 8'h00, 0, 0, 0);
        send(0, mk(8'h00, 0, 0), 14, 92, 92, -1, -1);
        do_ack(0);
`ifdef MAJORITY_VOTE_EN
        push(0, 8'h00, 0, 0, 0);
`else
        push(0, 8'h01, 0, 0, 0);
`endif
        send(0, mk(8'h00, 0, 0), 14, 96, 96, -1, -1);
        do_ack(0);

        repeat (10) @(negedge clk);
        check("scoreboard_drained_dut0", q_n.size(), 32'h0);
        check("scoreboard_drained_dut1", q_p.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
